// File: rtl/sa_operand_feeder.sv
// Operand buffer and diagonal-skew streamer for an N x N systolic matrix multiplier.
// Holds A (row-major) and B (column-major) operands, then feeds array edges with skew.
module sa_operand_feeder #(
  parameter int data_size = 4,
  parameter int N         = 4,
  localparam int IDX_W    = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load_valid,
  input  logic                      load_sel,
  input  logic [IDX_W-1:0]          load_row,
  input  logic [IDX_W-1:0]          load_col,
  input  logic [data_size-1:0]      load_data,
  input  logic                      start,
  output logic [N*data_size-1:0]    a_out,
  output logic [N*data_size-1:0]    b_out,
  output logic                      pe_clear,
  output logic                      busy,
  output logic                      done
);

  localparam int T_W = $clog2(3*N-2);
  localparam logic [T_W-1:0] T_LAST = T_W'(3*N-3);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [T_W-1:0]         t_q, t_d;
  logic [data_size-1:0]   a_mem_q [N][N];
  logic [data_size-1:0]   a_mem_d [N][N];
  logic [data_size-1:0]   b_mem_q [N][N];
  logic [data_size-1:0]   b_mem_d [N][N];
  logic [N*data_size-1:0] a_out_q, a_out_d;
  logic [N*data_size-1:0] b_out_q, b_out_d;
  logic                   pe_clear_q, pe_clear_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   idx_ok;

  assign idx_ok = ({1'b0, load_row} < (IDX_W+1)'(N)) && ({1'b0, load_col} < (IDX_W+1)'(N));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      S_IDLE: begin
        t_d = '0;
        if (start) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        t_d     = '0;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (t_q == T_LAST) state_d = S_DONE;
        else               t_d     = t_q + 1'b1;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_mem_d = a_mem_q;
    b_mem_d = b_mem_q;
    if (state_q == S_IDLE && load_valid && idx_ok) begin
      if (load_sel) b_mem_d[load_row][load_col] = load_data;
      else          a_mem_d[load_row][load_col] = load_data;
    end
  end

  // Outputs are registered against the next state so step t lands in the cycle it belongs to.
  // Storage cannot change once the FSM leaves IDLE, so reading the current copy is safe.
  always_comb begin
    a_out_d    = '0;
    b_out_d    = '0;
    pe_clear_d = (state_d == S_CLEAR);
    busy_d     = (state_d == S_CLEAR) || (state_d == S_STREAM);
    done_d     = (state_d == S_DONE);
    if (state_d == S_STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_d) == i + k) begin
            a_out_d[i*data_size +: data_size] = a_mem_q[i][k];
            b_out_d[i*data_size +: data_size] = b_mem_q[k][i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      t_q        <= '0;
      a_out_q    <= '0;
      b_out_q    <= '0;
      pe_clear_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          a_mem_q[r][c] <= '0;
          b_mem_q[r][c] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      t_q        <= t_d;
      a_out_q    <= a_out_d;
      b_out_q    <= b_out_d;
      pe_clear_q <= pe_clear_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      a_mem_q    <= a_mem_d;
      b_mem_q    <= b_mem_d;
    end
  end

  assign a_out    = a_out_q;
  assign b_out    = b_out_q;
  assign pe_clear = pe_clear_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_sa_operand_feeder.sv
// Directed bench for sa_operand_feeder with a behavioural N x N PE array on its outputs.
module tb_sa_operand_feeder;

  localparam int DS = 4;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic          load_sel;
  logic [1:0]    load_row;
  logic [1:0]    load_col;
  logic [DS-1:0] load_data;
  logic          start;
  logic [N*DS-1:0] a_out;
  logic [N*DS-1:0] b_out;
  logic          pe_clear;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int clr_cnt  = 0;
  int lat;

  sa_operand_feeder #(.data_size(DS), .N(N)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_sel(load_sel),
    .load_row(load_row), .load_col(load_col), .load_data(load_data), .start(start),
    .a_out(a_out), .b_out(b_out), .pe_clear(pe_clear), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural array: operands hop right/down one PE per cycle, accumulator cleared by pe_clear.
  int                acc   [N][N];
  logic signed [DS-1:0] a_reg [N][N];
  logic signed [DS-1:0] b_reg [N][N];
  logic signed [DS-1:0] ai, bi;

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        acc[i][j] = 0; a_reg[i][j] = '0; b_reg[i][j] = '0;
      end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) ai = $signed(a_out[i*DS +: DS]);
        else        ai = a_reg[i][j-1];
        if (i == 0) bi = $signed(b_out[j*DS +: DS]);
        else        bi = b_reg[i-1][j];
        if (pe_clear) begin
          acc[i][j]   <= 0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end else begin
          acc[i][j]   <= acc[i][j] + int'(ai) * int'(bi);
          a_reg[i][j] <= ai;
          b_reg[i][j] <= bi;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (done)     done_cnt++;
    if (pe_clear) clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic sel, input int row, input int col, input int data);
    load_valid = 1'b1;
    load_sel   = sel;
    load_row   = 2'(row);
    load_col   = 2'(col);
    load_data  = DS'(data);
    tick();
    load_valid = 1'b0;
  endtask

  task automatic check_acc_all(input string tag, input int exp);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check(tag, acc[i][j], exp);
  endtask

  // inj: stream step at which a stray start/load is driven (-100 = none).
  task automatic run(input int inj, input bit skew, input bit same_ld, output int l);
    done_cnt = 0;
    clr_cnt  = 0;
    start    = 1'b1;
    if (same_ld) begin
      load_valid = 1'b1; load_sel = 1'b0; load_row = 2'd0; load_col = 2'd0; load_data = 4'd5;
    end
    tick();
    start      = 1'b0;
    load_valid = 1'b0;
    l = 1;
    check("clear_cycle_pe_clear", pe_clear, 1);
    check("clear_cycle_busy", busy, 1);
    while (done !== 1'b1 && l < 40) begin
      if (l == inj + 2) begin
        start = 1'b1; load_valid = 1'b1; load_sel = 1'b0;
        load_row = 2'd0; load_col = 2'd0; load_data = 4'd7;
      end
      tick();
      l++;
      start      = 1'b0;
      load_valid = 1'b0;
      if (skew && l >= 2 && l <= 11) begin
        check("skew_b_zero", b_out, 0);
        if (l == 2)  check("skew_t0", a_out, 16'h0001);
        if (l == 5)  check("skew_t3", a_out, 16'h1234);
        if (l == 11) check("skew_t9", a_out, 16'h0000);
      end
    end
    check("latency", l, 12);
    check("done_busy_low", busy, 0);
    check("done_outputs_zero", {a_out, b_out}, 0);
    repeat (3) @(posedge clk);
    #1;
    check("done_count", done_cnt, 1);
    check("clear_count", clr_cnt, 1);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_row = '0; load_col = '0;
    load_data = '0; start = 1'b0;
    tick(); tick();
    check("reset_a_out", a_out, 0);
    check("reset_b_out", b_out, 0);
    check("reset_pe_clear", pe_clear, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    reset = 1'b0;
    tick();

    // Identity x B
    for (int r = 0; r < N; r++) begin
      load(1'b0, r, r, 1);
      for (int c = 0; c < N; c++) load(1'b1, r, c, r*4 + c - 8);
    end
    run(-100, 1'b0, 1'b0, lat);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check("identity_out", acc[i][j], i*4 + j - 8);

    // Skew: A[i][k] = k+1, B = 0
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, c + 1);
        load(1'b1, r, c, 0);
      end
    run(-100, 1'b1, 1'b0, lat);
    check_acc_all("skew_zero_product", 0);

    // Signed products
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, -8);
        load(1'b1, r, c, 1);
      end
    run(-100, 1'b0, 1'b0, lat);
    check_acc_all("signed_neg32", -32);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) load(1'b1, r, c, -1);
    run(-100, 1'b0, 1'b0, lat);
    check_acc_all("signed_pos32", 32);

    // Stray start and write during STREAM are ignored
    run(2, 1'b0, 1'b0, lat);
    check_acc_all("ignored_run", 32);
    run(-100, 1'b0, 1'b0, lat);
    check_acc_all("ignored_rerun", 32);

    // Same-cycle load + start: A = 0 except A[0][0] = 5 written with start, B = I
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        load(1'b0, r, c, 0);
        load(1'b1, r, c, (r == c) ? 1 : 0);
      end
    run(-100, 1'b0, 1'b1, lat);
    check("same_cycle_00", acc[0][0], 5);
    check("same_cycle_11", acc[1][1], 0);

    // Reset at stream step 4
    done_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_a_out", a_out, 0);
    check("midreset_b_out", b_out, 0);
    check("midreset_pe_clear", pe_clear, 0);
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    repeat (15) tick();
    check("midreset_no_done", done_cnt, 0);
    run(-100, 1'b0, 1'b0, lat);
    check_acc_all("after_reset_cleared", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
